// File: rtl/blit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : blit_pkg
//  Purpose  : Shared types and constants for the blitter inner-loop sequencer.
//             Holds the sequencer state enum, the pixel-size codes and a
//             helper that returns how many pixels fit in one 64-bit phrase.
//  Config   : BLIT_COLLIDE_STOP_EN adds the ST_STOP state.
//  Revision : 1.0  initial release
// ============================================================================
package blit_pkg;

  localparam int PHRASE_BYTES = 8;
  localparam int PHRASE_BITS  = PHRASE_BYTES * 8;

  // pixsize codes: bits per pixel = 1 << code
  localparam logic [2:0] PIX_1BPP  = 3'd0;
  localparam logic [2:0] PIX_2BPP  = 3'd1;
  localparam logic [2:0] PIX_4BPP  = 3'd2;
  localparam logic [2:0] PIX_8BPP  = 3'd3;
  localparam logic [2:0] PIX_16BPP = 3'd4;
  localparam logic [2:0] PIX_32BPP = 3'd5;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SREAD  = 4'd1,
    ST_DREAD  = 4'd2,
    ST_COMP   = 4'd3,
    ST_WCHK   = 4'd4,
    ST_DWRITE = 4'd5,
    ST_NEXT   = 4'd6,
    ST_DONE   = 4'd7
`ifdef BLIT_COLLIDE_STOP_EN
    ,
    ST_STOP   = 4'd8
`endif
  } blit_state_e;

  // Pixels held in one phrase; codes 6 and 7 behave as 32 bpp.
  function automatic logic [6:0] pix_per_phrase(input logic [2:0] pixsize);
    logic [2:0] shift;
    case (pixsize)
      PIX_1BPP:  shift = 3'd0;
      PIX_2BPP:  shift = 3'd1;
      PIX_4BPP:  shift = 3'd2;
      PIX_8BPP:  shift = 3'd3;
      PIX_16BPP: shift = 3'd4;
      PIX_32BPP: shift = 3'd5;
      default:   shift = 3'd5;
    endcase
    return 7'(PHRASE_BITS) >> shift;
  endfunction

endpackage
`default_nettype wire

// File: rtl/blit_step_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : blit_step_cnt
//  Purpose  : Combinational step sizer. Works out how many pixels the current
//             inner-loop step covers and the matching icount for comp_ctrl.
//  Ports    : pixsize     in  pixel size code (6,7 act as 32 bpp)
//             phrase_mode in  1 = whole-phrase steps, 0 = single pixel
//             remaining   in  pixels still to process
//             step_pix    out pixels in this step (never exceeds remaining)
//             icount      out (step_pix - 1)[2:0]
//  Revision : 1.0  initial release
// ============================================================================
module blit_step_cnt
  import blit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic [2:0]       pixsize,
  input  logic             phrase_mode,
  input  logic [CNT_W-1:0] remaining,
  output logic [CNT_W-1:0] step_pix,
  output logic [2:0]       icount
);

  // Compare in a width that holds both operands so a narrow CNT_W cannot
  // truncate the phrase capacity.
  logic [CNT_W+6:0] ppp_ext;
  logic [CNT_W+6:0] rem_ext;

  always_comb begin
    ppp_ext = {{CNT_W{1'b0}}, pix_per_phrase(pixsize)};
    rem_ext = {7'd0, remaining};
    if (!phrase_mode) begin
      step_pix = CNT_W'(1);
    end else if (rem_ext < ppp_ext) begin
      step_pix = remaining;
    end else begin
      step_pix = CNT_W'(ppp_ext);
    end
    icount = step_pix[2:0] - 3'd1;
  end

endmodule
`default_nettype wire

// File: rtl/blit_inner_seq.sv
`default_nettype none
// ============================================================================
//  Module   : blit_inner_seq
//  Purpose  : Blitter inner-loop sequencer. For each step: optional source
//             read, optional destination read, a comparator pulse, then a
//             byte-masked destination write unless comp_ctrl vetoes it.
//  Config   : BLIT_COLLIDE_STOP_EN adds coll_stop/resume/stopped and a STOP
//             state entered when a vetoed write coincides with coll_stop.
//  Ports    : sys_clk, reset          clock, async active-high reset
//             start, inner_cnt        begin loop / pixel count (IDLE only)
//             pixsize, phrase_mode    step sizing config (latched on start)
//             srcen, dsten            per-step read enables (latched)
//             abort                   cancel loop (never cuts a handshake)
//             nowrite, dbinh_n        comp_ctrl verdict, sampled in WCHK
//             mem_ack                 memory accepted current request
//             mem_req/mem_wr/mem_src  request, direction, source select
//             mem_be                  write byte enables
//             step_inner, icount      comparator pulse and step size - 1
//             busy, inner_done        activity and completion pulse
//  Revision : 1.0  initial release
// ============================================================================
module blit_inner_seq
  import blit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] inner_cnt,
  input  logic [2:0]       pixsize,
  input  logic             phrase_mode,
  input  logic             srcen,
  input  logic             dsten,
  input  logic             abort,
  input  logic             nowrite,
  input  logic [7:0]       dbinh_n,
  input  logic             mem_ack,
`ifdef BLIT_COLLIDE_STOP_EN
  input  logic             coll_stop,
  input  logic             resume,
  output logic             stopped,
`endif
  output logic             mem_req,
  output logic             mem_wr,
  output logic             mem_src,
  output logic [7:0]       mem_be,
  output logic             step_inner,
  output logic [2:0]       icount,
  output logic             busy,
  output logic             inner_done
);

  blit_state_e      state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [2:0]       pixsize_q, pixsize_d;
  logic             phrase_q, phrase_d;
  logic             srcen_q, srcen_d;
  logic             dsten_q, dsten_d;
  logic [7:0]       be_q, be_d;
  // Remembers an abort seen mid-handshake so a one-cycle abort pulse still
  // ends the loop once the access is acknowledged.
  logic             abort_pend_q, abort_pend_d;

  logic [CNT_W-1:0] step_pix;
  logic [2:0]       step_icount;
  logic             abort_now;
  logic             step_active;

  blit_step_cnt #(
    .CNT_W (CNT_W)
  ) u_step_cnt (
    .pixsize     (pixsize_q),
    .phrase_mode (phrase_q),
    .remaining   (remaining_q),
    .step_pix    (step_pix),
    .icount      (step_icount)
  );

  function automatic blit_state_e first_state(input logic s, input logic d);
    if (s) begin
      return ST_SREAD;
    end else if (d) begin
      return ST_DREAD;
    end
    return ST_COMP;
  endfunction

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    pixsize_d    = pixsize_q;
    phrase_d     = phrase_q;
    srcen_d      = srcen_q;
    dsten_d      = dsten_q;
    be_d         = be_q;
    abort_pend_d = abort_pend_q;
    abort_now    = abort | abort_pend_q;

    case (state_q)
      ST_IDLE: begin
        abort_pend_d = 1'b0;
        if (start) begin
          remaining_d = inner_cnt;
          pixsize_d   = pixsize;
          phrase_d    = phrase_mode;
          srcen_d     = srcen;
          dsten_d     = dsten;
          if (inner_cnt == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = first_state(srcen, dsten);
          end
        end
      end

      ST_SREAD: begin
        if (abort) begin
          abort_pend_d = 1'b1;
        end
        if (mem_ack) begin
          if (abort_now) begin
            state_d = ST_IDLE;
          end else if (dsten_q) begin
            state_d = ST_DREAD;
          end else begin
            state_d = ST_COMP;
          end
        end
      end

      ST_DREAD: begin
        if (abort) begin
          abort_pend_d = 1'b1;
        end
        if (mem_ack) begin
          state_d = abort_now ? ST_IDLE : ST_COMP;
        end
      end

      ST_COMP: begin
        state_d = abort ? ST_IDLE : ST_WCHK;
      end

      ST_WCHK: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (nowrite) begin
`ifdef BLIT_COLLIDE_STOP_EN
          state_d = coll_stop ? ST_STOP : ST_NEXT;
`else
          state_d = ST_NEXT;
`endif
        end else begin
          // An all-zero mask still produces a write cycle.
          be_d    = dbinh_n;
          state_d = ST_DWRITE;
        end
      end

      ST_DWRITE: begin
        if (abort) begin
          abort_pend_d = 1'b1;
        end
        if (mem_ack) begin
          state_d = abort_now ? ST_IDLE : ST_NEXT;
        end
      end

      ST_NEXT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          // step_pix never exceeds remaining_q, so this cannot wrap.
          remaining_d = remaining_q - step_pix;
          if (remaining_d == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = first_state(srcen_q, dsten_q);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

`ifdef BLIT_COLLIDE_STOP_EN
      ST_STOP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (resume) begin
          state_d = ST_NEXT;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs decode straight from the state register so an async reset
    // drops the request in the same instant.
    mem_req     = (state_q == ST_SREAD) || (state_q == ST_DREAD) ||
                  (state_q == ST_DWRITE);
    mem_wr      = (state_q == ST_DWRITE);
    mem_src     = (state_q == ST_SREAD);
    mem_be      = be_q;
    step_inner  = (state_q == ST_COMP);
    busy        = (state_q != ST_IDLE);
    inner_done  = (state_q == ST_DONE);
`ifdef BLIT_COLLIDE_STOP_EN
    stopped     = (state_q == ST_STOP);
`endif

    // remaining_q only moves in NEXT, so icount is steady for the whole
    // step; outside a step it reads zero.
    step_active = (state_q == ST_SREAD) || (state_q == ST_DREAD) ||
                  (state_q == ST_COMP)  || (state_q == ST_WCHK)  ||
                  (state_q == ST_DWRITE);
`ifdef BLIT_COLLIDE_STOP_EN
    step_active = step_active || (state_q == ST_STOP);
`endif
    icount      = step_active ? step_icount : 3'd0;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      pixsize_q    <= 3'd0;
      phrase_q     <= 1'b0;
      srcen_q      <= 1'b0;
      dsten_q      <= 1'b0;
      be_q         <= 8'h00;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      pixsize_q    <= pixsize_d;
      phrase_q     <= phrase_d;
      srcen_q      <= srcen_d;
      dsten_q      <= dsten_d;
      be_q         <= be_d;
      abort_pend_q <= abort_pend_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_blit_inner_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blit_inner_seq
//  Purpose  : Self-checking bench for blit_inner_seq. A reference model
//             derives the expected memory transactions and icount sequence
//             from the loop parameters and the per-step comp_ctrl plan.
//  Revision : 1.0  initial release
// ============================================================================
module tb_blit_inner_seq;

  logic        sys_clk = 1'b0;
  logic        reset, start, phrase_mode, srcen, dsten, abort, nowrite, mem_ack;
  logic [15:0] inner_cnt;
  logic [2:0]  pixsize;
  logic [7:0]  dbinh_n;
  logic        mem_req, mem_wr, mem_src, step_inner, busy, inner_done;
  logic [7:0]  mem_be;
  logic [2:0]  icount;
`ifdef BLIT_COLLIDE_STOP_EN
  logic        coll_stop, resume, stopped;
`endif

  blit_inner_seq #(.CNT_W(16)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .start       (start),
    .inner_cnt   (inner_cnt),
    .pixsize     (pixsize),
    .phrase_mode (phrase_mode),
    .srcen       (srcen),
    .dsten       (dsten),
    .abort       (abort),
    .nowrite     (nowrite),
    .dbinh_n     (dbinh_n),
    .mem_ack     (mem_ack),
`ifdef BLIT_COLLIDE_STOP_EN
    .coll_stop   (coll_stop),
    .resume      (resume),
    .stopped     (stopped),
`endif
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_src     (mem_src),
    .mem_be      (mem_be),
    .step_inner  (step_inner),
    .icount      (icount),
    .busy        (busy),
    .inner_done  (inner_done)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  // comp_ctrl plan, indexed by step number
  bit         plan_nw [0:255];
  logic [7:0] plan_be [0:255];

  // observation
  logic [9:0] obs_tx[$];
  logic [2:0] obs_ic[$];
  int         obs_len[$];
  int         step_idx, n_done, n_req_cycles, stab_err, cur_len;
  logic       prev_wr, prev_src;

  // reference
  logic [9:0] exp_tx[$];
  logic [2:0] exp_ic[$];

  // memory responder knobs
  int ack_max  = 0;
  bit ack_rand = 0;
  bit spur_en  = 0;

  task automatic tick();
    @(negedge sys_clk);
    #2;
  endtask

  // Memory side: ack after a chosen number of wait cycles; optionally
  // toggles ack randomly while no request is pending.
  initial begin
    int wait_cnt;
    int cur_delay;
    mem_ack   = 1'b0;
    wait_cnt  = 0;
    cur_delay = 0;
    forever begin
      @(negedge sys_clk);
      if (mem_req) begin
        if (wait_cnt == 0) cur_delay = ack_rand ? $urandom_range(ack_max, 0) : ack_max;
        if (wait_cnt >= cur_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
        end else begin
          mem_ack  = 1'b0;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        mem_ack  = spur_en ? 1'($urandom_range(1, 0)) : 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor plus comp_ctrl stand-in.
  initial begin
    forever begin
      @(negedge sys_clk);
      #1;
      if (mem_req) begin
        if (cur_len > 0 && (mem_wr !== prev_wr || mem_src !== prev_src)) stab_err++;
        cur_len++;
        n_req_cycles++;
        prev_wr  = mem_wr;
        prev_src = mem_src;
        if (mem_ack) begin
          obs_tx.push_back({mem_wr, mem_src, (mem_wr ? mem_be : 8'h00)});
          obs_len.push_back(cur_len);
          cur_len = 0;
        end
      end else begin
        cur_len = 0;
      end
      if (step_inner) begin
        obs_ic.push_back(icount);
        nowrite  = plan_nw[step_idx % 256];
        dbinh_n  = plan_be[step_idx % 256];
        step_idx++;
      end
      if (inner_done) n_done++;
    end
  end

  task automatic clear_mon();
    obs_tx.delete();
    obs_ic.delete();
    obs_len.delete();
    step_idx     = 0;
    n_done       = 0;
    n_req_cycles = 0;
    stab_err     = 0;
    cur_len      = 0;
  endtask

  task automatic set_plan(input bit rand_plan, input logic [7:0] be);
    for (int i = 0; i < 256; i++) begin
      plan_nw[i] = rand_plan ? ($urandom_range(3, 0) == 0) : 1'b0;
      plan_be[i] = rand_plan ? 8'($urandom) : be;
    end
  endtask

  // Reference: walk the loop pixel-count arithmetic directly.
  function automatic void build_exp(int cnt, int ps, bit pm, bit s, bit d);
    int rem, n, k, ppp;
    exp_tx.delete();
    exp_ic.delete();
    ppp = 64 / (1 << ((ps > 5) ? 5 : ps));
    rem = cnt;
    k   = 0;
    while (rem > 0) begin
      n = pm ? ((ppp < rem) ? ppp : rem) : 1;
      exp_ic.push_back(3'((n - 1) % 8));
      if (s) exp_tx.push_back({1'b0, 1'b1, 8'h00});
      if (d) exp_tx.push_back({1'b0, 1'b0, 8'h00});
      if (!plan_nw[k % 256]) exp_tx.push_back({1'b1, 1'b0, plan_be[k % 256]});
      rem -= n;
      k++;
    end
  endfunction

  task automatic start_loop(input int cnt, input int ps, input bit pm, input bit s, input bit d);
    tick();
    inner_cnt   = 16'(cnt);
    pixsize     = 3'(ps);
    phrase_mode = pm;
    srcen       = s;
    dsten       = d;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic run_loop(input int cnt, input int ps, input bit pm, input bit s, input bit d,
                          input bit glitch);
    bit got;
    clear_mon();
    build_exp(cnt, ps, pm, s, d);
    start_loop(cnt, ps, pm, s, d);
    got = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (n_done > 0) begin
        got = 1'b1;
        break;
      end
      if (glitch) begin
        start       = 1'($urandom_range(1, 0));
        inner_cnt   = 16'($urandom);
        pixsize     = 3'($urandom);
        phrase_mode = 1'($urandom);
        srcen       = 1'($urandom);
        dsten       = 1'($urandom);
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL loop_timeout cnt=%0d: inner_done not seen, required within 20000 cycles", cnt);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done: got %b required 0", busy);
    end
    tick();
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL done_pulses cnt=%0d: got %0d required 1", cnt, n_done);
    end
    checks++;
    if (obs_tx.size() !== exp_tx.size()) begin
      errors++;
      $display("FAIL tx_count cnt=%0d: got %0d required %0d", cnt, obs_tx.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i]) begin
        errors++;
        $display("FAIL tx[%0d] {wr,src,be}: got %h required %h", i, obs_tx[i], exp_tx[i]);
      end
    end
    checks++;
    if (obs_ic.size() !== exp_ic.size()) begin
      errors++;
      $display("FAIL step_count cnt=%0d: got %0d required %0d", cnt, obs_ic.size(), exp_ic.size());
    end
    for (int i = 0; i < exp_ic.size() && i < obs_ic.size(); i++) begin
      checks++;
      if (obs_ic[i] !== exp_ic[i]) begin
        errors++;
        $display("FAIL icount[%0d]: got %0d required %0d", i, obs_ic[i], exp_ic[i]);
      end
    end
    checks++;
    if (stab_err !== 0) begin
      errors++;
      $display("FAIL req_stable: got %0d changes while waiting, required 0", stab_err);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({mem_req, mem_wr, mem_src, mem_be, step_inner, icount, busy, inner_done} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {mem_req, mem_wr, mem_src, mem_be, step_inner, icount, busy, inner_done});
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_pixel_basic();
    set_plan(1'b0, 8'hFF);
    ack_max = 0; ack_rand = 0; spur_en = 0;
    run_loop(3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_phrase_16bpp();
    set_plan(1'b0, 8'h5A);
    run_loop(10, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_ic.size() !== 3) begin
      errors++;
      $display("FAIL phrase16_steps: got %0d required 3", obs_ic.size());
    end
  endtask

  task automatic test_reads_delayed();
    set_plan(1'b0, 8'hC3);
    ack_max = 4;
    run_loop(2, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < obs_len.size(); i++) begin
      checks++;
      if (obs_len[i] !== 5) begin
        errors++;
        $display("FAIL req_len[%0d]: got %0d cycles required 5", i, obs_len[i]);
      end
    end
    ack_max = 0;
  endtask

  task automatic test_nowrite_step2();
    set_plan(1'b0, 8'h00);  // zero mask still writes
    plan_nw[1] = 1'b1;
    run_loop(3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort_wait();
    int guard;
    clear_mon();
    ack_max = 6;
    start_loop(5, 0, 1'b0, 1'b1, 1'b0);
    guard = 0;
    while (!mem_req && guard < 20) begin tick(); guard++; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    guard = 0;
    while (obs_tx.size() == 0 && guard < 30) begin tick(); guard++; end
    checks++;
    if (obs_len.size() < 1 || obs_len[0] !== 7) begin
      errors++;
      $display("FAIL abort_req_len: got %0d transactions / first len %0d, required 1 / 7",
               obs_len.size(), (obs_len.size() > 0) ? obs_len[0] : -1);
    end
    tick();
    checks++;
    if ({busy, mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL abort_wait_idle {busy,req}: got %b required 00", {busy, mem_req});
    end
    repeat (4) tick();
    checks++;
    if (n_done !== 0 || obs_ic.size() !== 0 || obs_tx.size() !== 1) begin
      errors++;
      $display("FAIL abort_wait_quiet done/steps/tx: got %0d/%0d/%0d required 0/0/1",
               n_done, obs_ic.size(), obs_tx.size());
    end
    ack_max = 0;
  endtask

  task automatic test_abort_comp();
    int guard;
    set_plan(1'b0, 8'hFF);
    clear_mon();
    start_loop(5, 0, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (!step_inner && guard < 20) begin tick(); guard++; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, step_inner} !== 2'b00) begin
      errors++;
      $display("FAIL abort_comp_idle {busy,step}: got %b required 00", {busy, step_inner});
    end
    repeat (4) tick();
    checks++;
    if (n_done !== 0 || obs_tx.size() !== 0 || obs_ic.size() !== 1) begin
      errors++;
      $display("FAIL abort_comp_quiet done/tx/steps: got %0d/%0d/%0d required 0/0/1",
               n_done, obs_tx.size(), obs_ic.size());
    end
  endtask

  task automatic test_zero_cnt();
    clear_mon();
    start_loop(0, 0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({inner_done, busy} !== 2'b11) begin
      errors++;
      $display("FAIL zero_cnt_done {done,busy}: got %b required 11", {inner_done, busy});
    end
    tick();
    checks++;
    if ({inner_done, busy, n_req_cycles != 0} !== 3'b000) begin
      errors++;
      $display("FAIL zero_cnt_after {done,busy,req_seen}: got %b required 000",
               {inner_done, busy, n_req_cycles != 0});
    end
  endtask

  task automatic test_reset_mid_write();
    int guard;
    set_plan(1'b0, 8'hA5);
    clear_mon();
    ack_max = 10;
    start_loop(2, 0, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (!(mem_req && mem_wr) && guard < 20) begin tick(); guard++; end
    checks++;
    if (!(mem_req && mem_wr)) begin
      errors++;
      $display("FAIL reset_mid_write_setup: write request not seen, required within 20 cycles");
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_wr, mem_src, mem_be, step_inner, icount, busy, inner_done} !== 17'd0) begin
      errors++;
      $display("FAIL reset_mid_write: got %h required 0",
               {mem_req, mem_wr, mem_src, mem_be, step_inner, icount, busy, inner_done});
    end
    tick();
    reset   = 1'b0;
    ack_max = 0;
    tick();
  endtask

  task automatic test_random();
    int cnt, ps;
    bit pm, s, d;
    ack_rand = 1; ack_max = 3; spur_en = 1;
    for (int it = 0; it < 30; it++) begin
      set_plan(1'b1, 8'h00);
      pm  = 1'($urandom);
      ps  = $urandom_range(7, 0);
      cnt = pm ? $urandom_range(100, 0) : $urandom_range(40, 0);
      s   = 1'($urandom);
      d   = 1'($urandom);
      run_loop(cnt, ps, pm, s, d, 1'b1);
    end
    ack_rand = 0; ack_max = 0; spur_en = 0;
  endtask

`ifdef BLIT_COLLIDE_STOP_EN
  task automatic test_collide_stop();
    int guard;
    set_plan(1'b0, 8'hFF);
    plan_nw[1] = 1'b1;
    clear_mon();
    coll_stop = 1'b1;
    start_loop(3, 0, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (!stopped && guard < 40) begin tick(); guard++; end
    repeat (5) tick();
    checks++;
    if ({stopped, busy} !== 2'b11 || obs_tx.size() !== 1 || obs_ic.size() !== 2) begin
      errors++;
      $display("FAIL collide_stop {stopped,busy}/tx/steps: got %b/%0d/%0d required 11/1/2",
               {stopped, busy}, obs_tx.size(), obs_ic.size());
    end
    coll_stop = 1'b0;
    resume    = 1'b1;
    tick();
    resume    = 1'b0;
    guard = 0;
    while (n_done == 0 && guard < 40) begin tick(); guard++; end
    checks++;
    if (n_done !== 1 || obs_tx.size() !== 2 || obs_ic.size() !== 3) begin
      errors++;
      $display("FAIL collide_resume done/tx/steps: got %0d/%0d/%0d required 1/2/3",
               n_done, obs_tx.size(), obs_ic.size());
    end
    repeat (2) tick();
  endtask
`endif

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    inner_cnt   = 16'd0;
    pixsize     = 3'd0;
    phrase_mode = 1'b0;
    srcen       = 1'b0;
    dsten       = 1'b0;
    abort       = 1'b0;
    nowrite     = 1'b0;
    dbinh_n     = 8'h00;
`ifdef BLIT_COLLIDE_STOP_EN
    coll_stop   = 1'b0;
    resume      = 1'b0;
`endif
    clear_mon();
    test_reset();
    test_pixel_basic();
    test_phrase_16bpp();
    test_reads_delayed();
    test_nowrite_step2();
    test_abort_wait();
    test_abort_comp();
    test_zero_cnt();
    test_reset_mid_write();
`ifdef BLIT_COLLIDE_STOP_EN
    test_collide_stop();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
